// File: rtl/sysid_boot_checker.sv
// Boot-time check of the system-ID slave (ID at address 0, timestamp at address 1)
// with retry, pass/fail status, and a shared host read port served once checking is done.
//
// state  | meaning
// SETTLE | idle for SETTLE_CYCLES cycles before an attempt
// RD_ID  | slave address 0 driven, ID compared at the clock edge
// RD_TS  | slave address 1 driven, timestamp compared at the clock edge
// EVAL   | decide pass, retry, or fail
// DONE   | status valid; host owns the slave address port
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS   = 32'h582B_7F4D,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          MAX_RETRY     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sys_address,
    input  logic [31:0] sys_readdata,
    input  logic        host_read,
    input  logic        host_address,
    output logic        host_waitrequest,
    output logic        host_readdatavalid,
    output logic [31:0] host_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  retry_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {SETTLE, RD_ID, RD_TS, EVAL, DONE} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          id_ok_q, id_ok_n;
    logic          ts_ok_q, ts_ok_n;
    logic          pass_q, pass_n;
    logic          fail_q, fail_n;
    logic [1:0]    retry_q, retry_n;
    logic          addr_mux;
    logic          host_accept;
    logic          rdv_q;
    logic [31:0]   rdata_q;

    assign host_accept = host_read & (state_q == DONE) & ~reset;

    always_comb begin
        state_n  = state_q;
        cnt_n    = '0;
        id_ok_n  = id_ok_q;
        ts_ok_n  = ts_ok_q;
        pass_n   = pass_q;
        fail_n   = fail_q;
        retry_n  = retry_q;
        addr_mux = 1'b0;
        case (state_q)
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_n = RD_ID;
                else                      cnt_n   = cnt_q + 1'b1;
            end
            RD_ID: begin
                id_ok_n = (sys_readdata == EXPECTED_ID);
                state_n = RD_TS;
            end
            RD_TS: begin
                addr_mux = 1'b1;
                ts_ok_n  = (sys_readdata == EXPECTED_TS);
                state_n  = EVAL;
            end
            EVAL: begin
                if (id_ok_q && ts_ok_q) begin
                    pass_n  = 1'b1;
                    state_n = DONE;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    retry_n = retry_q + 2'd1;
                    id_ok_n = 1'b0;
                    ts_ok_n = 1'b0;
                    state_n = SETTLE;
                end else begin
                    fail_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                addr_mux = host_read ? host_address : 1'b0;
                // A same-cycle host read is still served; only the status is restarted.
                if (start) begin
                    pass_n  = 1'b0;
                    fail_n  = 1'b0;
                    retry_n = 2'd0;
                    id_ok_n = 1'b0;
                    ts_ok_n = 1'b0;
                    state_n = SETTLE;
                end
            end
            default: state_n = SETTLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            retry_q <= 2'd0;
            rdv_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            id_ok_q <= id_ok_n;
            ts_ok_q <= ts_ok_n;
            pass_q  <= pass_n;
            fail_q  <= fail_n;
            retry_q <= retry_n;
            rdv_q   <= host_accept;
            if (host_accept) rdata_q <= sys_readdata;
        end
    end

    // Outputs are forced to their reset values for the whole cycle reset is high,
    // not just from the edge after it is sampled.
    assign sys_address        = addr_mux & ~reset;
    assign busy               = reset | (state_q != DONE);
    assign done               = ~reset & (state_q == DONE);
    assign pass               = pass_q & ~reset;
    assign fail               = fail_q & ~reset;
    assign retry_count        = reset ? 2'd0 : retry_q;
    assign host_waitrequest   = reset | (state_q != DONE);
    assign host_readdatavalid = rdv_q & ~reset;
    assign host_readdata      = reset ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: per-cycle vector table for the nominal boot and
// host reads, plus hand sequences for retries, mid-sequence reset and start-with-read.
module tb_sysid_boot_checker;

    localparam logic [31:0] TS_GOOD = 32'h582B_7F4D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        host_read = 1'b0;
    logic        host_address = 1'b0;
    logic        sys_address;
    logic [31:0] sys_readdata;
    logic        host_waitrequest, host_readdatavalid;
    logic [31:0] host_readdata;
    logic        busy, done, pass, fail;
    logic [1:0]  retry_count;

    logic [31:0] id_val = 32'h0;
    logic [31:0] ts_val = TS_GOOD;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    assign sys_readdata = sys_address ? ts_val : id_val;

    sysid_boot_checker dut (
        .clock(clock), .reset(reset), .start(start),
        .sys_address(sys_address), .sys_readdata(sys_readdata),
        .host_read(host_read), .host_address(host_address),
        .host_waitrequest(host_waitrequest), .host_readdatavalid(host_readdatavalid),
        .host_readdata(host_readdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .retry_count(retry_count)
    );

    typedef struct {
        logic        hr;
        logic        ha;
        logic        e_busy;
        logic        e_done;
        logic        e_pass;
        logic        e_wait;
        logic        e_rdv;
        logic        e_sa;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic eb, input logic ed,
                              input logic ep, input logic ef, input logic [1:0] er);
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, eb});
        chk({tag, ".done"}, {31'b0, done}, {31'b0, ed});
        chk({tag, ".pass"}, {31'b0, pass}, {31'b0, ep});
        chk({tag, ".fail"}, {31'b0, fail}, {31'b0, ef});
        chk({tag, ".retry"}, {30'b0, retry_count}, {30'b0, er});
        chk({tag, ".wait"}, {31'b0, host_waitrequest}, {31'b0, ~ed});
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) next_cycle();
        reset = 1'b0;
        cyc = 1;
    endtask

    initial begin
        // hr ha | busy done pass wait rdv sa rdata   (cycle = index+1 after reset release)
        vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, TS_GOOD});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, TS_GOOD});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, TS_GOOD});
        vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, TS_GOOD});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});

        // Nominal boot, host read held during the check, then back-to-back reads.
        reset = 1'b1;
        next_cycle();
        @(negedge clock);
        chk_status("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst.rdv", {31'b0, host_readdatavalid}, 32'h0);
        chk("rst.rdata", host_readdata, 32'h0);
        chk("rst.sa", {31'b0, sys_address}, 32'h0);
        apply_reset(1);
        for (int i = 0; i < vq.size(); i++) begin
            host_read    = vq[i].hr;
            host_address = vq[i].ha;
            @(negedge clock);
            chk("tbl.busy", {31'b0, busy}, {31'b0, vq[i].e_busy});
            chk("tbl.done", {31'b0, done}, {31'b0, vq[i].e_done});
            chk("tbl.pass", {31'b0, pass}, {31'b0, vq[i].e_pass});
            chk("tbl.fail", {31'b0, fail}, 32'h0);
            chk("tbl.retry", {30'b0, retry_count}, 32'h0);
            chk("tbl.wait", {31'b0, host_waitrequest}, {31'b0, vq[i].e_wait});
            chk("tbl.rdv", {31'b0, host_readdatavalid}, {31'b0, vq[i].e_rdv});
            chk("tbl.sa", {31'b0, sys_address}, {31'b0, vq[i].e_sa});
            chk("tbl.rdata", host_readdata, vq[i].e_rdata);
            next_cycle();
        end
        host_read = 1'b0;

        // Timestamp permanently wrong: four attempts then fail.
        ts_val = 32'h1234_5678;
        apply_reset(2);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            chk_status("badts", c < 29, c >= 29, 1'b0, c >= 29,
                       (c >= 22) ? 2'd3 : (c >= 15) ? 2'd2 : (c >= 8) ? 2'd1 : 2'd0);
            chk("badts.inv", {31'b0, pass & fail}, 32'h0);
            next_cycle();
        end
        ts_val = TS_GOOD;

        // Wrong ID on the first attempt only; a start pulse while busy is ignored.
        apply_reset(2);
        for (int c = 1; c <= 16; c++) begin
            id_val = (c <= 7) ? 32'hDEAD_BEEF : 32'h0;
            start  = (c == 10);
            @(negedge clock);
            chk_status("badid", c < 15, c >= 15, c >= 15, 1'b0, (c >= 8) ? 2'd1 : 2'd0);
            next_cycle();
        end
        start  = 1'b0;
        id_val = 32'h0;

        // Reset during RD_ID, reset with a pending read, then start plus host read in DONE.
        apply_reset(2);
        for (int c = 1; c <= 4; c++) next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk_status("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("midrst.sa", {31'b0, sys_address}, 32'h0);
        next_cycle();
        reset = 1'b0;
        cyc = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            chk_status("after_rst", c < 8, c >= 8, c >= 8, 1'b0, 2'd0);
            next_cycle();
        end
        host_read = 1'b1;
        host_address = 1'b1;
        next_cycle();
        host_read = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("droprdv.rdv", {31'b0, host_readdatavalid}, 32'h0);
        chk("droprdv.rdata", host_readdata, 32'h0);
        next_cycle();
        reset = 1'b0;
        cyc = 1;
        @(negedge clock);
        chk("droprdv.rdv_after", {31'b0, host_readdatavalid}, 32'h0);
        for (int c = 1; c <= 8; c++) next_cycle();
        host_read = 1'b1;
        host_address = 1'b1;
        @(negedge clock);
        chk_status("predone", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        next_cycle();
        start = 1'b1;
        host_read = 1'b1;
        host_address = 1'b0;
        @(negedge clock);
        chk("st.rdata_prev", host_readdata, TS_GOOD);
        chk("st.wait", {31'b0, host_waitrequest}, 32'h0);
        chk("st.sa", {31'b0, sys_address}, 32'h0);
        next_cycle();
        start = 1'b0;
        host_read = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (c == 1) begin
                chk("st.rdv", {31'b0, host_readdatavalid}, 32'h1);
                chk("st.rdata", host_readdata, 32'h0);
            end
            chk_status("rerun", c < 8, c >= 8, c >= 8, 1'b0, 2'd0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
